conv_tile_scheduler: RTL and testbench
======================================

Name: conv_tile_scheduler

Overview:
- Layer-level sequencer in front of the CNN convolution core.
- Walks the output-channel tiles (co) in the outer loop and the input-channel tiles (ci) in the inner loop.
- For each (co, ci) pair it presents ci/co, issues a one-cycle start_conv and waits for end_conv.
- Tells the output-accumulation path when to clear or accumulate, and reports layer completion or abort to the host/top controller.

Parameters:
- TILE_W, 2, width of the ci/co tile indices; matches the CNN core ci/co ports.
- CNT_W, 16, width of the completed-tile counter.
- PERF_W, 32, width of the optional cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- layer_start  in  1  one-cycle request to run a layer; honoured only in IDLE.
- num_ci  in  TILE_W  input-channel tile count minus 1; latched on an accepted layer_start.
- num_co  in  TILE_W  output-channel tile count minus 1; latched on an accepted layer_start.
- abort  in  1  level; stops issuing new tiles.
- end_conv  in  1  completion pulse from the CNN core.
- start_conv  out  1  one-cycle launch pulse to the CNN core.
- ci  out  TILE_W  current input-channel tile index.
- co  out  TILE_W  current output-channel tile index.
- acc_first  out  1  high while the current tile has ci==0 (output path overwrites instead of accumulating).
- acc_last  out  1  high while the current tile has ci==num_ci_q (output path may write final results).
- busy  out  1  high in any state except IDLE.
- layer_done  out  1  one-cycle pulse when the layer finishes or aborts.
- aborted  out  1  valid with layer_done: 1 = the layer ended by abort.
- tiles_done  out  CNT_W  count of tiles completed in the current/last layer.

Behaviour:
- Reset (rst=0, async) values:
  - state = IDLE.
  - start_conv, busy, layer_done, aborted, acc_first, acc_last = 0.
  - ci = co = 0; tiles_done = 0.
- States: IDLE, LAUNCH, WAIT, NEXT, FINISH.
- IDLE:
  - On layer_start=1 with abort=0: latch num_ci_q/num_co_q, set ci=co=0, clear tiles_done, go to LAUNCH.
  - layer_start together with abort=1 is ignored.
- LAUNCH (exactly 1 cycle):
  - start_conv=1; go to WAIT.
  - ci, co, acc_first and acc_last are stable from LAUNCH through the end of WAIT.
- WAIT:
  - start_conv=0. On end_conv=1: tiles_done += 1, go to NEXT.
  - end_conv in any other state is ignored; no count change.
- NEXT (1 cycle):
  - If abort=1: go to FINISH with aborted=1.
  - Else if ci<num_ci_q: ci += 1, go to LAUNCH.
  - Else if co<num_co_q: ci=0, co += 1, go to LAUNCH.
  - Else: go to FINISH with aborted=0.
- FINISH (1 cycle): layer_done=1, aborted held as decided in NEXT; go to IDLE.
  - aborted stays valid until the next accepted layer_start.
- Abort rules:
  - Abort never cuts a tile in flight; the core always finishes and end_conv is consumed first.
  - Abort asserted in IDLE has no effect.
- Tile-count arithmetic and latency:
  - Tile count = (num_ci_q+1)*(num_co_q+1); max 16 with TILE_W=2.
  - The index counters never wrap: the comparison happens before the increment.
  - Latency from end_conv to the next start_conv = 2 cycles (NEXT, LAUNCH).
  - Layer_done arrives 2 cycles after the final end_conv.
- tiles_done saturates at all-ones.
- Reset mid-operation: immediate return to IDLE, all outputs at reset values. The core is not notified; the top level resets it on the same rst.
- num_ci/num_co changes while busy have no effect (latched values are used).

Optional Feature:
- Macro: TILE_PERF_CNT_EN.
- Defined:
  - Adds output perf_cycles [PERF_W-1:0].
  - Cleared on an accepted layer_start; increments every cycle while busy=1; saturates; holds after FINISH until the next start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- num_ci=1, num_co=1, core model answers end_conv 5 cycles after start_conv:
  - (co,ci) sequence (0,0),(0,1),(1,0),(1,1).
  - acc_first high on tiles 1 and 3; acc_last high on tiles 2 and 4.
  - tiles_done=4; layer_done pulse with aborted=0.
- num_ci=0, num_co=0: exactly one start_conv; layer_done 2 cycles after end_conv; tiles_done=1.
- num_ci=3, num_co=3:
  - 16 start_conv pulses, each 2 cycles after the previous end_conv.
  - ci never exceeds 3; final ci=3, co=3.
- Abort raised during the second tile's WAIT (num_ci=3, num_co=0):
  - No third start_conv; layer_done with aborted=1; tiles_done=2.
- Spurious end_conv in IDLE and layer_start while busy: no state change, no extra start_conv, tiles_done unchanged.
- rst pulled low in WAIT: outputs return to reset values at once; a new layer_start then runs normally.
- With TILE_PERF_CNT_EN, the single-tile run above: perf_cycles equals the busy duration (5 core cycles plus scheduler overhead, counted exactly).

Source files
------------

// File: rtl/conv_tile_scheduler.sv
// Layer sequencer: walks co (outer) / ci (inner) tiles and launches the conv core.
// Define TILE_PERF_CNT_EN to add the perf_cycles busy-cycle counter.
module conv_tile_scheduler #(
   parameter int TILE_W = 2,
   parameter int CNT_W  = 16,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              layer_start,
   input  logic [TILE_W-1:0] num_ci,
   input  logic [TILE_W-1:0] num_co,
   input  logic              abort,
   input  logic              end_conv,
   output logic              start_conv,
   output logic [TILE_W-1:0] ci,
   output logic [TILE_W-1:0] co,
   output logic              acc_first,
   output logic              acc_last,
   output logic              busy,
   output logic              layer_done,
   output logic              aborted,
`ifdef TILE_PERF_CNT_EN
   output logic [CNT_W-1:0]  tiles_done,
   output logic [PERF_W-1:0] perf_cycles
`else
   output logic [CNT_W-1:0]  tiles_done
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      NEXT,
      FINISH
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [TILE_W-1:0] ci_q;
   logic [TILE_W-1:0] co_q;
   logic [TILE_W-1:0] num_ci_q;
   logic [TILE_W-1:0] num_co_q;
   logic [CNT_W-1:0]  tiles_q;
   logic              aborted_q;
   logic              accept;
   logic              more;

   assign accept = (state_q == IDLE) && layer_start && !abort;
   assign more   = (ci_q < num_ci_q) || (co_q < num_co_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = LAUNCH;
         LAUNCH:  state_d = WAIT;
         WAIT:    if (end_conv) state_d = NEXT;
         NEXT: begin
            if (abort)     state_d = FINISH;
            else if (more) state_d = LAUNCH;
            else           state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Index compare precedes increment, so ci/co never wrap past the latched counts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ci_q      <= '0;
         co_q      <= '0;
         num_ci_q  <= '0;
         num_co_q  <= '0;
         tiles_q   <= '0;
         aborted_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  num_ci_q  <= num_ci;
                  num_co_q  <= num_co;
                  ci_q      <= '0;
                  co_q      <= '0;
                  tiles_q   <= '0;
                  aborted_q <= 1'b0;
               end
            end
            WAIT: begin
               if (end_conv && (tiles_q != '1))
                  tiles_q <= tiles_q + CNT_W'(1);
            end
            NEXT: begin
               if (abort) begin
                  aborted_q <= 1'b1;
               end else if (ci_q < num_ci_q) begin
                  ci_q <= ci_q + TILE_W'(1);
               end else if (co_q < num_co_q) begin
                  ci_q <= '0;
                  co_q <= co_q + TILE_W'(1);
               end else begin
                  aborted_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign start_conv = (state_q == LAUNCH);
   assign busy       = (state_q != IDLE);
   assign layer_done = (state_q == FINISH);
   assign aborted    = aborted_q;
   assign ci         = ci_q;
   assign co         = co_q;
   assign acc_first  = busy && (ci_q == '0);
   assign acc_last   = busy && (ci_q == num_ci_q);
   assign tiles_done = tiles_q;

`ifdef TILE_PERF_CNT_EN
   logic [PERF_W-1:0] perf_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         perf_q <= '0;
      else if (accept)
         perf_q <= '0;
      else if (busy && (perf_q != '1))
         perf_q <= perf_q + PERF_W'(1);
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: scoreboard of expected (co,ci,first,last)
// per start_conv, core model answering end_conv 5 cycles after launch.
module tb_conv_tile_scheduler;

   logic       clk;
   logic       rst;
   logic       layer_start;
   logic [1:0] num_ci;
   logic [1:0] num_co;
   logic       abort;
   logic       end_conv;
   logic       start_conv;
   logic [1:0] ci;
   logic [1:0] co;
   logic       acc_first;
   logic       acc_last;
   logic       busy;
   logic       layer_done;
   logic       aborted;
   logic [15:0] tiles_done;
`ifdef TILE_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   conv_tile_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .layer_start(layer_start),
      .num_ci     (num_ci),
      .num_co     (num_co),
      .abort      (abort),
      .end_conv   (end_conv),
      .start_conv (start_conv),
      .ci         (ci),
      .co         (co),
      .acc_first  (acc_first),
      .acc_last   (acc_last),
      .busy       (busy),
      .layer_done (layer_done),
      .aborted    (aborted),
`ifdef TILE_PERF_CNT_EN
      .tiles_done (tiles_done),
      .perf_cycles(perf_cycles)
`else
      .tiles_done (tiles_done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: end_conv exactly 5 cycles after each start_conv.
   logic [4:0] sr;
   logic       spur;
   always @(posedge clk or negedge rst) begin
      if (!rst) sr <= '0;
      else      sr <= {sr[3:0], start_conv};
   end
   assign end_conv = sr[4] | spur;

   int         tests;
   int         fails;
   int         cyc;
   int         last_end;
   int         starts;
   bit         first;
   bit         done_seen;
   logic       done_ab;
   logic [5:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [5:0] e;
      @(negedge clk);
      cyc++;
      if (rst && end_conv) last_end = cyc;
      if (start_conv) begin
         starts++;
         tests++;
         assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL start_unexpected: observed start_conv, expected none");
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tile", {26'd0, co, ci, acc_first, acc_last}, {26'd0, e});
         end
         if (!first) chk("start_lat", cyc - last_end, 2);
         first = 1'b0;
      end
      if (layer_done) begin
         done_seen = 1'b1;
         done_ab   = aborted;
         chk("done_lat", cyc - last_end, 2);
      end
   endtask

   task automatic start_layer(input int nci, input int nco, input int lim);
      int n;
      n = 0;
      for (int o = 0; o <= nco; o++)
         for (int i = 0; i <= nci; i++) begin
            if (n < lim)
               exp_q.push_back({o[1:0], i[1:0], i == 0, i == nci});
            n++;
         end
      first       = 1'b1;
      done_seen   = 1'b0;
      starts      = 0;
      num_ci      = nci[1:0];
      num_co      = nco[1:0];
      layer_start = 1'b1;
      tick();
      layer_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !done_seen; i++) tick();
      chk("done_seen", {31'd0, done_seen}, 1);
   endtask

   task automatic wait_starts(input int n, input int budget);
      for (int i = 0; i < budget && starts < n; i++) tick();
      chk("starts_reached", starts, n);
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      cyc         = 0;
      last_end    = 0;
      starts      = 0;
      first       = 1'b1;
      done_seen   = 1'b0;
      done_ab     = 1'b0;
      rst         = 1'b0;
      layer_start = 1'b0;
      num_ci      = '0;
      num_co      = '0;
      abort       = 1'b0;
      spur        = 1'b0;
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_start", {31'd0, start_conv}, 0);
      chk("rst_done", {31'd0, layer_done}, 0);
      chk("rst_abt", {31'd0, aborted}, 0);
      chk("rst_first", {31'd0, acc_first}, 0);
      chk("rst_last", {31'd0, acc_last}, 0);
      chk("rst_cico", {28'd0, co, ci}, 0);
      chk("rst_tiles", {16'd0, tiles_done}, 0);
      rst = 1'b1;
      tick();

      // layer_start with abort high is ignored
      abort       = 1'b1;
      layer_start = 1'b1;
      tick();
      layer_start = 1'b0;
      abort       = 1'b0;
      tick();
      chk("abort_start_ignored", {31'd0, busy}, 0);

      // 2x2 tiles
      start_layer(1, 1, 99);
      wait_done(200);
      chk("t1_tiles", {16'd0, tiles_done}, 4);
      chk("t1_abt", {31'd0, done_ab}, 0);
      chk("t1_q", exp_q.size(), 0);
      tick();

      // single tile
      start_layer(0, 0, 99);
      wait_done(100);
      chk("t2_tiles", {16'd0, tiles_done}, 1);
      chk("t2_starts", starts, 1);
      tick();
`ifdef TILE_PERF_CNT_EN
      chk("t2_perf", perf_cycles, 8);
`endif
      chk("t2_idle_first", {31'd0, acc_first}, 0);

      // 4x4 tiles
      start_layer(3, 3, 99);
      wait_done(400);
      chk("t3_tiles", {16'd0, tiles_done}, 16);
      chk("t3_starts", starts, 16);
      chk("t3_cico", {28'd0, co, ci}, 32'hf);
      chk("t3_q", exp_q.size(), 0);
      tick();

      // abort during second tile WAIT
      start_layer(3, 0, 2);
      wait_starts(2, 100);
      tick();
      abort = 1'b1;
      wait_done(100);
      abort = 1'b0;
      chk("t4_abt", {31'd0, done_ab}, 1);
      chk("t4_tiles", {16'd0, tiles_done}, 2);
      chk("t4_starts", starts, 2);
      tick();
      chk("t4_abt_hold", {31'd0, aborted}, 1);

      // spurious end_conv in IDLE
      spur = 1'b1;
      tick();
      spur = 1'b0;
      tick();
      tick();
      chk("t5_tiles", {16'd0, tiles_done}, 2);
      chk("t5_busy", {31'd0, busy}, 0);
      chk("t5_starts", starts, 2);

      // layer_start while busy
      start_layer(1, 0, 99);
      wait_starts(1, 50);
      tick();
      num_ci      = 2'd3;
      num_co      = 2'd3;
      layer_start = 1'b1;
      tick();
      layer_start = 1'b0;
      wait_done(100);
      chk("t6_tiles", {16'd0, tiles_done}, 2);
      chk("t6_cico", {28'd0, co, ci}, 1);
      chk("t6_q", exp_q.size(), 0);
      tick();

      // reset in WAIT
      start_layer(3, 3, 99);
      wait_starts(2, 50);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("r_busy", {31'd0, busy}, 0);
      chk("r_start", {31'd0, start_conv}, 0);
      chk("r_done", {31'd0, layer_done}, 0);
      chk("r_abt", {31'd0, aborted}, 0);
      chk("r_first", {31'd0, acc_first}, 0);
      chk("r_last", {31'd0, acc_last}, 0);
      chk("r_cico", {28'd0, co, ci}, 0);
      chk("r_tiles", {16'd0, tiles_done}, 0);
      exp_q.delete();
      tick();
      rst = 1'b1;
      tick();
      start_layer(1, 1, 99);
      wait_done(200);
      chk("r2_tiles", {16'd0, tiles_done}, 4);
      chk("r2_abt", {31'd0, done_ab}, 0);
      chk("r2_q", exp_q.size(), 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
